// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
// adc_capture_pkg : shared types and constants for the ADC capture controller
// Rev 1.0
// ============================================================================
package adc_capture_pkg;

    localparam int FRAME_CNT_W = 16;

    // Header word layout: the frame counter occupies bits upward from this LSB.
    localparam int HDR_CNT_LSB = 0;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_ARMED   = 4'b0010,
        S_CAPTURE = 4'b0100,
        S_DRAIN   = 4'b1000
    } state_t;

    function automatic logic [31:0] hdr_field(input logic [FRAME_CNT_W-1:0] cnt);
        return 32'(cnt) << HDR_CNT_LSB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// adc_capture_ctrl_if : ADC stream in / FIFO write port bundle
// Rev 1.0
// ============================================================================
interface adc_capture_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  adc_valid, adc_data, full, empty,
        output wr_en, wr_data
    );

    modport slave (
        output adc_valid, adc_data, full, empty,
        input  wr_en, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/trig_edge.sv
`default_nettype none
// ============================================================================
// trig_edge : rising-edge detector on trig, one-cycle pulse on the edge cycle
// Rev 1.0
// ============================================================================
module trig_edge (
    input  logic clk,
    input  logic rstn,
    input  logic trig,
    output logic rise
);
    logic r_trig_d;

    always_ff @(posedge clk) begin
        if (!rstn) r_trig_d <= 1'b0;
        else       r_trig_d <= trig;
    end

    assign rise = trig & ~r_trig_d;
endmodule
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// adc_capture_ctrl : triggered one-frame ADC capture into the sample FIFO
// Option ADC_CAPTURE_HEADER_EN: first word of each frame is the frame count.
// Rev 1.0
// ============================================================================
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SAMPLES = 1024,
    parameter int CNT_W   = $clog2(SAMPLES + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   arm,
    input  logic                   trig,
    adc_capture_ctrl_if.master     bus,
    output logic                   capturing,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overflow
);
    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_word_cnt, w_word_cnt_nxt;
    logic                   r_seen_data, w_seen_data_nxt;
    logic                   r_wr_en, w_wr_en_nxt;
    logic [DATA_W-1:0]      r_wr_data, w_wr_data_nxt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic                   r_overflow, w_overflow_nxt;
    logic                   w_trig_rise;
    logic                   w_take;
    logic [DATA_W-1:0]      w_word;

    trig_edge u_trig_edge (
        .clk  (clk),
        .rstn (rstn),
        .trig (trig),
        .rise (w_trig_rise)
    );

`ifdef ADC_CAPTURE_HEADER_EN
    logic              r_hdr_pending, w_hdr_pending_nxt;
    logic [DATA_W-1:0] w_hdr_word;

    // Header goes out on the first CAPTURE cycle regardless of adc_valid.
    assign w_hdr_word = DATA_W'(hdr_field(r_frame_cnt));
    assign w_take     = r_hdr_pending | bus.adc_valid;
    assign w_word     = r_hdr_pending ? w_hdr_word : bus.adc_data;
`else
    assign w_take     = bus.adc_valid;
    assign w_word     = bus.adc_data;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_word_cnt_nxt  = r_word_cnt;
        w_seen_data_nxt = r_seen_data;
        w_wr_en_nxt     = 1'b0;
        w_wr_data_nxt   = r_wr_data;
        w_frame_cnt_nxt = r_frame_cnt;
        w_overflow_nxt  = r_overflow;
`ifdef ADC_CAPTURE_HEADER_EN
        w_hdr_pending_nxt = r_hdr_pending;
`endif
        case (r_state)
            S_IDLE: begin
                if (arm) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!arm) begin
                    w_state_nxt = S_IDLE;
                end else if (w_trig_rise) begin
                    w_state_nxt     = S_CAPTURE;
                    w_word_cnt_nxt  = '0;
                    w_seen_data_nxt = 1'b0;
`ifdef ADC_CAPTURE_HEADER_EN
                    w_hdr_pending_nxt = 1'b1;
`endif
                end
            end
            S_CAPTURE: begin
                if (!bus.empty) w_seen_data_nxt = 1'b1;
`ifdef ADC_CAPTURE_HEADER_EN
                w_hdr_pending_nxt = 1'b0;
`endif
                if (w_take) begin
                    if (bus.full) begin
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = S_DRAIN;
                    end else begin
                        w_wr_en_nxt    = 1'b1;
                        w_wr_data_nxt  = w_word;
                        w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
                        if (r_word_cnt == CNT_W'(SAMPLES - 1)) begin
                            w_frame_cnt_nxt = r_frame_cnt + FRAME_CNT_W'(1);
                            w_state_nxt     = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.empty) w_seen_data_nxt = 1'b1;
                // A stale empty from before the frame landed must not end the drain.
                if (bus.empty && r_seen_data)
                    w_state_nxt = arm ? S_ARMED : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_word_cnt  <= '0;
            r_seen_data <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
`ifdef ADC_CAPTURE_HEADER_EN
            r_hdr_pending <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_seen_data <= w_seen_data_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_overflow  <= w_overflow_nxt;
`ifdef ADC_CAPTURE_HEADER_EN
            r_hdr_pending <= w_hdr_pending_nxt;
`endif
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_data = r_wr_data;
    assign capturing   = (r_state == S_CAPTURE);
    assign frame_cnt   = r_frame_cnt;
    assign overflow    = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// tb_adc_capture_ctrl : directed bench for adc_capture_ctrl, SAMPLES=8, FIFO model depth 8
// Rev 1.0
// ============================================================================
module tb_adc_capture_ctrl;
    import adc_capture_pkg::*;

`ifdef ADC_CAPTURE_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        arm;
    logic        trig;
    logic [15:0] frame_cnt;
    logic        capturing;
    logic        overflow;

    int total;
    int bad;
    int exp_frames;

    // FIFO model: read side starts on full, stops on empty
    int          fcnt;
    int          nxt;
    bit          rd_active;
    bit          force_full;
    bit          force_empty;
    bit          fifo_clr;
    logic [15:0] wlog[$];

    adc_capture_ctrl_if #(.DATA_W(16)) bus ();

    adc_capture_ctrl #(.DATA_W(16), .SAMPLES(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .arm       (arm),
        .trig      (trig),
        .bus       (bus.master),
        .capturing (capturing),
        .frame_cnt (frame_cnt),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.full  = force_full  || (fcnt == 8);
        bus.empty = force_empty || (fcnt == 0);
    end

    always @(posedge clk) begin
        if (fifo_clr) begin
            fcnt      <= 0;
            rd_active <= 1'b0;
        end else begin
            nxt = fcnt;
            if (bus.wr_en && fcnt < 8) nxt = nxt + 1;
            if (rd_active && fcnt > 0) nxt = nxt - 1;
            fcnt <= nxt;
            if (bus.full)      rd_active <= 1'b1;
            else if (nxt == 0) rd_active <= 1'b0;
        end
        if (bus.wr_en) wlog.push_back(bus.wr_data);
    end

    function automatic logic [15:0] exp_word(input int j, input logic [15:0] hdr, input logic [15:0] base);
        return (HDR_EN && j == 0) ? hdr : base + 16'(j);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input state_t s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dut.r_state == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic fire_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic run_cont(input logic [15:0] base);
        fire_trig();
        for (int i = 0; i < 8; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = base + 16'(i);
            tick();
        end
        bus.adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        fifo_clr = 1'b1;
        tick();
        tick();
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %0b want 0", bus.wr_en); end
        total++; if (bus.wr_data !== 16'h0) begin bad++; $display("FAIL reset_wr_data: got %0h want 0", bus.wr_data); end
        total++; if (capturing !== 1'b0) begin bad++; $display("FAIL reset_capturing: got %0b want 0", capturing); end
        total++; if (frame_cnt !== 16'h0) begin bad++; $display("FAIL reset_frame_cnt: got %0h want 0", frame_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        total++; if (dut.r_state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0h want %0h", dut.r_state, S_IDLE); end
        rstn = 1'b1;
        fifo_clr = 1'b0;
        exp_frames = 0;
    endtask

    task automatic test_basic();
        bit ok;
        logic [15:0] hdr;
        wlog.delete();
        arm = 1'b1;
        wait_state(S_ARMED, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_armed: got %0h want %0h", dut.r_state, S_ARMED); end
        hdr = 16'(exp_frames);
        fire_trig();
        total++; if (capturing !== 1'b1) begin bad++; $display("FAIL basic_capturing_start: got %0b want 1", capturing); end
        for (int i = 0; i < 8; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = 16'h0001 + 16'(i);
            tick();
            total++;
            if (bus.wr_en !== 1'b1 || bus.wr_data !== exp_word(i, hdr, 16'h0001)) begin
                bad++;
                $display("FAIL basic_write[%0d]: got en=%0b data=%0h want en=1 data=%0h", i, bus.wr_en, bus.wr_data, exp_word(i, hdr, 16'h0001));
            end
        end
        bus.adc_valid = 1'b0;
        exp_frames++;
        total++; if (capturing !== 1'b0) begin bad++; $display("FAIL basic_capturing_end: got %0b want 0", capturing); end
        total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL basic_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        total++; if (dut.r_state !== S_DRAIN) begin bad++; $display("FAIL basic_drain: got %0h want %0h", dut.r_state, S_DRAIN); end
        wait_state(S_ARMED, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_rearm: got %0h want %0h", dut.r_state, S_ARMED); end
        total++; if (fcnt !== 0) begin bad++; $display("FAIL basic_fifo_drained: got %0d want 0", fcnt); end
        total++; if (wlog.size() !== 8) begin bad++; $display("FAIL basic_write_count: got %0d want 8", wlog.size()); end
    endtask

    task automatic test_gappy();
        bit ok;
        logic [15:0] hdr;
        wlog.delete();
        hdr = 16'(exp_frames);
        fire_trig();
        for (int k = 0; k < 10; k++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = 16'h0100 + 16'(k);
            tick();
            bus.adc_valid = 1'b0;
            tick();
            tick();
        end
        wait_state(S_ARMED, 40, ok);
        exp_frames++;
        total++; if (!ok) begin bad++; $display("FAIL gappy_rearm: got %0h want %0h", dut.r_state, S_ARMED); end
        total++; if (wlog.size() !== 8) begin bad++; $display("FAIL gappy_write_count: got %0d want 8", wlog.size()); end
        for (int j = 0; j < 8 && j < wlog.size(); j++) begin
            total++;
            if (wlog[j] !== exp_word(j, hdr, 16'h0100)) begin
                bad++;
                $display("FAIL gappy_word[%0d]: got %0h want %0h", j, wlog[j], exp_word(j, hdr, 16'h0100));
            end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL gappy_overflow: got %0b want 0", overflow); end
        total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL gappy_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_stale_empty();
        bit ok;
        wlog.delete();
        force_empty = 1'b1;
        run_cont(16'h0600);
        exp_frames++;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (dut.r_state !== S_DRAIN) begin bad++; $display("FAIL stale_hold[%0d]: got %0h want %0h", c, dut.r_state, S_DRAIN); end
            tick();
        end
        force_empty = 1'b0;
        wait_state(S_ARMED, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL stale_rearm: got %0h want %0h", dut.r_state, S_ARMED); end
        total++; if (fcnt !== 0) begin bad++; $display("FAIL stale_fifo_drained: got %0d want 0", fcnt); end
        total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL stale_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_ignored_events();
        bit ok;
        logic [15:0] hdr;
        wlog.delete();
        hdr = 16'(exp_frames);
        fire_trig();
        for (int i = 0; i < 8; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = 16'h0200 + 16'(i);
            if (i == 2) trig = 1'b1;
            if (i == 3) begin trig = 1'b0; arm = 1'b0; end
            tick();
        end
        bus.adc_valid = 1'b0;
        exp_frames++;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_state(S_IDLE, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL ignored_idle: got %0h want %0h", dut.r_state, S_IDLE); end
        repeat (5) tick();
        total++; if (dut.r_state !== S_IDLE) begin bad++; $display("FAIL ignored_stay_idle: got %0h want %0h", dut.r_state, S_IDLE); end
        total++; if (wlog.size() !== 8) begin bad++; $display("FAIL ignored_write_count: got %0d want 8", wlog.size()); end
        if (wlog.size() == 8) begin
            total++; if (wlog[7] !== exp_word(7, hdr, 16'h0200)) begin bad++; $display("FAIL ignored_last_word: got %0h want %0h", wlog[7], exp_word(7, hdr, 16'h0200)); end
        end
        total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL ignored_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [15:0] hdr;
        wlog.delete();
        arm = 1'b1;
        wait_state(S_ARMED, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_armed: got %0h want %0h", dut.r_state, S_ARMED); end
        hdr = 16'(exp_frames);
        fire_trig();
        for (int i = 0; i < 6; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = 16'h0300 + 16'(i);
            if (i == 5) force_full = 1'b1;
            tick();
        end
        bus.adc_valid = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL ovf_no_write: got %0b want 0", bus.wr_en); end
        total++; if (dut.r_state !== S_DRAIN) begin bad++; $display("FAIL ovf_drain: got %0h want %0h", dut.r_state, S_DRAIN); end
        total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL ovf_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        total++; if (wlog.size() !== 5) begin bad++; $display("FAIL ovf_write_count: got %0d want 5", wlog.size()); end
        if (wlog.size() == 5) begin
            total++; if (wlog[4] !== exp_word(4, hdr, 16'h0300)) begin bad++; $display("FAIL ovf_last_word: got %0h want %0h", wlog[4], exp_word(4, hdr, 16'h0300)); end
        end
        tick();
        tick();
        force_full = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dut.r_state !== S_DRAIN) begin ok = 1'b1; break; end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL ovf_drain_exit: got %0h want %0h", dut.r_state, S_ARMED); end
        total++; if (fcnt !== 0) begin bad++; $display("FAIL ovf_exit_empty: got %0d want 0", fcnt); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        fire_trig();
        for (int i = 0; i < 4; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = 16'h0700 + 16'(i);
            tick();
        end
        rstn = 1'b0;
        tick();
        bus.adc_valid = 1'b0;
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL midrst_wr_en: got %0b want 0", bus.wr_en); end
        total++; if (bus.wr_data !== 16'h0) begin bad++; $display("FAIL midrst_wr_data: got %0h want 0", bus.wr_data); end
        total++; if (capturing !== 1'b0) begin bad++; $display("FAIL midrst_capturing: got %0b want 0", capturing); end
        total++; if (frame_cnt !== 16'h0) begin bad++; $display("FAIL midrst_frame_cnt: got %0h want 0", frame_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midrst_overflow: got %0b want 0", overflow); end
        total++; if (dut.r_state !== S_IDLE) begin bad++; $display("FAIL midrst_state: got %0h want %0h", dut.r_state, S_IDLE); end
        rstn = 1'b1;
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        exp_frames = 0;
    endtask

`ifdef ADC_CAPTURE_HEADER_EN
    task automatic test_header();
        bit ok;
        arm = 1'b1;
        wait_state(S_ARMED, 20, ok);
        run_cont(16'h0400);
        wait_state(S_ARMED, 40, ok);
        wlog.delete();
        run_cont(16'h0500);
        wait_state(S_ARMED, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL hdr_rearm: got %0h want %0h", dut.r_state, S_ARMED); end
        total++; if (wlog.size() !== 8) begin bad++; $display("FAIL hdr_write_count: got %0d want 8", wlog.size()); end
        if (wlog.size() == 8) begin
            total++; if (wlog[0] !== 16'h0001) begin bad++; $display("FAIL hdr_word: got %0h want 0001", wlog[0]); end
            total++; if (wlog[1] !== 16'h0501) begin bad++; $display("FAIL hdr_first_sample: got %0h want 0501", wlog[1]); end
            total++; if (wlog[7] !== 16'h0507) begin bad++; $display("FAIL hdr_last_sample: got %0h want 0507", wlog[7]); end
        end
    endtask
`endif

    initial begin
        total         = 0;
        bad           = 0;
        exp_frames    = 0;
        rstn          = 1'b0;
        arm           = 1'b0;
        trig          = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_data  = 16'h0;
        force_full    = 1'b0;
        force_empty   = 1'b0;
        fifo_clr      = 1'b1;

        test_reset();
        test_basic();
        test_gappy();
        test_stale_empty();
        test_ignored_events();
        test_overflow();
        test_reset_mid_frame();
`ifdef ADC_CAPTURE_HEADER_EN
        test_header();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
